// File: rtl/axi_hs_pkg.sv
// Shared constants, types and helpers for the valid/ready stream receiver.
// Imported by the FIFO and by the receiver top.
package axi_hs_pkg;

    localparam int DATA_W_DEF = 32;

    typedef enum logic [0:0] {
        SEQ_IDLE  = 1'b0,
        SEQ_TRACK = 1'b1
    } seq_state_e;

    // Bits needed to index 'value' entries (value >= 2).
    function automatic int clog2(input int value);
        int bits;
        bits = 0;
        for (int i = 0; i < 31; i++) begin
            if (((value - 1) >> i) != 0) begin
                bits = i + 1;
            end else begin
                bits = bits;
            end
        end
        return bits;
    endfunction

endpackage

// File: rtl/hs_sync_fifo.sv
// Small synchronous FIFO with registered pointers/occupancy and an unregistered head read.
// Storage is intentionally not reset; only pointers and occupancy are.
module hs_sync_fifo
    import axi_hs_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 4,
    localparam int PTR_W = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              full,
    output logic              empty,
    output logic [PTR_W:0]    count
);

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_r;
    logic [PTR_W-1:0]  rd_ptr_r;
    logic [PTR_W:0]    count_r;
    logic              push_ok_s;
    logic              pop_ok_s;

    // Qualify requests against current occupancy.
    always_comb begin
        push_ok_s = push && (count_r != (PTR_W + 1)'(DEPTH));
        pop_ok_s  = pop && (count_r != (PTR_W + 1)'(0));
    end

    // Storage write; contents survive reset and are masked by the occupancy.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= (PTR_W + 1)'(0);
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (PTR_W + 1)'(1);
                2'b01:   count_r <= count_r - (PTR_W + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    assign head  = mem_r[rd_ptr_r];
    assign full  = (count_r == (PTR_W + 1)'(DEPTH));
    assign empty = (count_r == (PTR_W + 1)'(0));
    assign count = count_r;

endmodule

// File: rtl/axi_stream_rx.sv
// Receiving end of the valid/ready stream: buffers accepted words, applies backpressure,
// and checks that accepted words form a +1 sequence while counting beats and errors.
module axi_stream_rx
    import axi_hs_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 4,
    parameter int ERR_W  = 16,
    localparam int PTR_W = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] data,
    input  logic              valid,
    output logic              ready,
    input  logic              stall,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       beat_count,
    output logic              seq_err,
    output logic [ERR_W-1:0]  err_count
);

    logic              full_s;
    logic              empty_s;
    logic [PTR_W:0]    fifo_count_s;
    logic              accept_s;
    logic              pop_s;
    seq_state_e        state_r;
    logic [DATA_W-1:0] expected_r;
    logic              seq_err_r;
    logic [31:0]       beat_count_r;
    logic [ERR_W-1:0]  err_count_r;

    // Ready depends only on registered occupancy and stall, never on valid/out_ready.
    always_comb begin
        ready    = !full_s && !stall;
        accept_s = valid && ready && !rst;
        pop_s    = out_ready && !empty_s;
    end

    hs_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (accept_s),
        .wdata (data),
        .pop   (pop_s),
        .head  (out_data),
        .full  (full_s),
        .empty (empty_s),
        .count (fifo_count_s)
    );

    assign out_valid = (fifo_count_s != (PTR_W + 1)'(0));

    // Sequence checker; every accepted beat resyncs the expected word to data+1.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= SEQ_IDLE;
            expected_r   <= DATA_W'(0);
            seq_err_r    <= 1'b0;
            beat_count_r <= 32'd0;
            err_count_r  <= ERR_W'(0);
        end else if (accept_s) begin
            beat_count_r <= beat_count_r + 32'd1;
            expected_r   <= data + DATA_W'(1);
            case (state_r)
                SEQ_IDLE: begin
                    state_r   <= SEQ_TRACK;
                    seq_err_r <= 1'b0;
                end
                SEQ_TRACK: begin
                    state_r <= SEQ_TRACK;
                    if (data != expected_r) begin
                        seq_err_r <= 1'b1;
                        if (err_count_r != {ERR_W{1'b1}}) begin
                            err_count_r <= err_count_r + ERR_W'(1);
                        end
                    end else begin
                        seq_err_r <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= SEQ_IDLE;
                    seq_err_r <= 1'b0;
                end
            endcase
        end else begin
            seq_err_r <= 1'b0;
        end
    end

    assign seq_err    = seq_err_r;
    assign beat_count = beat_count_r;
    assign err_count  = err_count_r;

endmodule

// File: doc/axi_stream_rx.md
Name: axi_stream_rx

Overview:
- Receiving (slave) end of the team's valid/ready handshake; sits directly opposite the counter-driven master that streams 32-bit words.
- Accepts beats into a small synchronous FIFO and exerts backpressure via ready.
- Presents buffered words on a downstream valid/ready port.
- Checks that accepted words form a +1 sequence and counts accepted beats and sequence errors for the bench.

Parameters:
- DATA_W, 32, width of data word on both ports.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- ERR_W, 16, width of the saturating sequence-error counter.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous, active-high reset.
- data  input  DATA_W  upstream word.
- valid  input  1  upstream word valid.
- ready  output  1  this block can accept a word this cycle.
- stall  input  1  bench/system backpressure; forces ready low.
- out_data  output  DATA_W  FIFO head word.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  downstream accepts head.
- beat_count  output  32  accepted upstream beats, wraps modulo 2^32.
- seq_err  output  1  one-cycle pulse on a sequence mismatch.
- err_count  output  ERR_W  total mismatches, saturating.

Behaviour:

Handshake and backpressure:
- ready = !full && !stall.
  - Combinational from registered count and stall only.
  - Never depends on valid or out_ready; no full-FIFO pass-through.
- Push: valid && ready sampled at posedge; data written at tail; count+1.
- Pop: out_valid && out_ready at posedge; head advances; count-1.
- Simultaneous push and pop: count unchanged; both pointers advance.
  - Possible only when not full.
  - When empty, the pushed word appears on out_data the next cycle; no same-cycle bypass.
- out_valid = (count != 0); out_data = mem[rd_ptr].
- Read latency: 1 cycle from accept to out_valid.
- Pointers are log2(DEPTH) bits and wrap naturally; count is log2(DEPTH)+1 bits.
- Upstream may hold valid with changing data while ready is low; only words captured on a handshake matter.

Sequence checker:
- State machine SEQ_IDLE / SEQ_TRACK.
- SEQ_IDLE (after reset): the first accepted beat loads expected = data+1 (mod 2^DATA_W) and moves to SEQ_TRACK. The first beat is never an error.
- SEQ_TRACK, each accepted beat:
  - If data != expected: seq_err = 1 the next cycle, and err_count increments, saturating at all-ones.
  - In all cases expected <= data+1, so the checker resyncs after a gap.
- Wrap from all-ones to 0 is legal and is not an error.
- A repeated word (data == expected-1) is an error.
- beat_count increments on every accepted beat; wraps.

Reset (rst=1 at posedge):
- ready = !stall combinationally, i.e. ready=1 with stall=0, from the first cycle after reset.
- out_valid=0; out_data is don't-care (mem is not reset).
- beat_count=0, seq_err=0, err_count=0; state SEQ_IDLE; pointers and count = 0.
- Mid-operation reset discards FIFO contents. No beat is accepted on a reset cycle even if valid && ready.

Error cases:
- Pop with out_valid=0 is ignored.
- Push with ready=0 is ignored; FIFO contents and counters are unchanged.

Decomposition:
- Package axi_hs_pkg:
  - DATA_W default constant.
  - Sequence state enum (SEQ_IDLE, SEQ_TRACK).
  - Function clog2 for pointer widths.
- One sub-module: hs_sync_fifo (DATA_W, DEPTH; push/pop/full/empty/count/head).
- The top module holds the ready logic, sequence checker and counters.

Test Plan:
- Reset: rst high for 2 cycles, stall=0 -> ready=1, out_valid=0, beat_count=0, err_count=0, seq_err=0.
- Fill: out_ready=0, valid=1, data 10,11,12,13,14 -> ready drops after the 4th accept; word 14 held off; beat_count=4. Then out_ready=1 -> out_data 10,11,12,13 in order, then 14 accepted.
- Streaming: valid=1 and out_ready=1 continuously, data 0..99 -> one accept per cycle, count stays <= 1, out_data lags data by 1 cycle, err_count=0, beat_count=100.
- Gap and repeat:
  - Accept 5,6,8,9,9,10 -> seq_err pulses after 8 and after the second 9 (the repeat).
  - 10 is clean, since the second 9 resyncs expected to 10; err_count=2.
- Wrap: accept 32'hFFFFFFFE, 32'hFFFFFFFF, 0, 1 -> no seq_err; beat_count=4.
- Stall and mid-op reset:
  - stall=1 with valid=1 -> ready=0, no accepts.
  - Fill 3 words, assert rst -> next cycle out_valid=0, counters 0.
  - First post-reset beat 500 gives no error; then 502 gives err_count=1.
